// File: rtl/con_fsm_pkg.sv
// Shared constants and types for the lab-CPU control unit: opcodes, FSM states, RAM address mux codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: CON_FSM_STEP_EN adds the WAIT state used for single-stepping.
package con_fsm_pkg;

    // Default geometry of the 8-bit lab CPU instruction word.
    localparam int DEF_OP_W   = 4;
    localparam int DEF_REG_AW = 2;
    localparam int DEF_IR_W   = 8;
    localparam int DEF_CNT_W  = 16;

    // Opcode map; 0xB..0xE are undefined and execute as NOP with the illegal flag.
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_MOVA = 4'h1;
    localparam logic [3:0] OPC_MOVB = 4'h2;
    localparam logic [3:0] OPC_MOVC = 4'h3;
    localparam logic [3:0] OPC_MOVI = 4'h4;
    localparam logic [3:0] OPC_ADD  = 4'h5;
    localparam logic [3:0] OPC_SUB  = 4'h6;
    localparam logic [3:0] OPC_JMP  = 4'h7;
    localparam logic [3:0] OPC_JG   = 4'h8;
    localparam logic [3:0] OPC_IN   = 4'h9;
    localparam logic [3:0] OPC_OUT  = 4'hA;
    localparam logic [3:0] OPC_HALT = 4'hF;

    // RAM address mux select.
    localparam logic [1:0] S_PC = 2'b00;
    localparam logic [1:0] S_SR = 2'b01;
    localparam logic [1:0] S_DR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_IMM   = 3'd3,
        ST_MEM   = 3'd4,
        ST_HALT  = 3'd5
`ifdef CON_FSM_STEP_EN
        , ST_WAIT = 3'd6
`endif
    } state_e;

    typedef enum logic [3:0] {
        I_NOP, I_MOVA, I_MOVB, I_MOVC, I_MOVI, I_ADD, I_SUB,
        I_JMP, I_JG, I_IN, I_OUT, I_HALT, I_ILL
    } instr_e;

    // Instruction class as seen by the sequencer.
    typedef struct packed {
        instr_e instr;
        logic   to_imm;   // needs an immediate word fetched after EXEC
        logic   to_mem;   // needs a data RAM access after EXEC
        logic   illegal;  // undefined opcode
    } dec_t;

endpackage

// File: rtl/con_fsm_if.sv
// Bundle between the control unit and the datapath: inputs the FSM samples plus every strobe it drives.
// Latency: n/a (wires only).
// Backpressure: mem_ready is the only stall source; the controller holds its RAM strobes until it is seen.
// master: the control unit (drives strobes/status). slave: the datapath side (drives start/ir/g/mem_ready).
interface con_fsm_if
    import con_fsm_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int IR_W   = DEF_IR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic [IR_W-1:0]   ir;
    logic              g;
    logic              mem_ready;

    logic              ir_ld;
    logic              pc_in;
    logic              pc_ld;
    logic              ram_re;
    logic              ram_wr;
    logic              reg_we;
    logic              gf_en;
    logic              in_en;
    logic              out_en;
    logic              au_en;
    logic              mux_s;
    logic [REG_AW-1:0] reg_sr;
    logic [REG_AW-1:0] reg_dr;
    logic [1:0]        s;
    logic [OP_W-1:0]   au_ac;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        input  start, ir, g, mem_ready,
        output ir_ld, pc_in, pc_ld, ram_re, ram_wr, reg_we, gf_en, in_en, out_en,
               au_en, mux_s, reg_sr, reg_dr, s, au_ac, halted, illegal, instr_cnt
    );

    modport slave (
        output start, ir, g, mem_ready,
        input  ir_ld, pc_in, pc_ld, ram_re, ram_wr, reg_we, gf_en, in_en, out_en,
               au_en, mux_s, reg_sr, reg_dr, s, au_ac, halted, illegal, instr_cnt
    );
endinterface

// File: rtl/con_fsm_dec.sv
// Opcode -> instruction-class decode for the control unit.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: op_i opcode field of IR; dec_o class (instr, to_imm, to_mem, illegal).
module con_dec
    import con_fsm_pkg::*;
#(
    parameter int OP_W = DEF_OP_W
) (
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o.instr   = I_NOP;
        dec_o.to_imm  = 1'b0;
        dec_o.to_mem  = 1'b0;
        dec_o.illegal = 1'b0;
        case (op_i)
            OP_W'(OPC_NOP):  dec_o.instr = I_NOP;
            OP_W'(OPC_MOVA): dec_o.instr = I_MOVA;
            OP_W'(OPC_MOVB): begin dec_o.instr = I_MOVB; dec_o.to_mem = 1'b1; end
            OP_W'(OPC_MOVC): begin dec_o.instr = I_MOVC; dec_o.to_mem = 1'b1; end
            OP_W'(OPC_MOVI): begin dec_o.instr = I_MOVI; dec_o.to_imm = 1'b1; end
            OP_W'(OPC_ADD):  dec_o.instr = I_ADD;
            OP_W'(OPC_SUB):  dec_o.instr = I_SUB;
            OP_W'(OPC_JMP):  begin dec_o.instr = I_JMP;  dec_o.to_imm = 1'b1; end
            OP_W'(OPC_JG):   begin dec_o.instr = I_JG;   dec_o.to_imm = 1'b1; end
            OP_W'(OPC_IN):   dec_o.instr = I_IN;
            OP_W'(OPC_OUT):  dec_o.instr = I_OUT;
            OP_W'(OPC_HALT): dec_o.instr = I_HALT;
            default: begin
                // Undefined opcodes behave as NOP but are flagged.
                dec_o.instr   = I_ILL;
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/con_fsm.sv
// Multi-cycle control unit for the 8-bit lab CPU: fetch/decode/sequence, datapath strobes, retired-instruction count.
// Latency: 2 cycles per register instruction (FETCH, EXEC), 3 for immediate/memory ones, plus RAM stall cycles.
// Backpressure: FETCH/IMM/MEM hold their RAM strobes and state while mem_ready is low.
// Ports: clk, rst_n (async active-low), bus (con_fsm_if.master: start/ir/g/mem_ready in, strobes/status out).
// Build option CON_FSM_STEP_EN: adds input step; after each retire the FSM parks in WAIT until step=1.
module con_fsm
    import con_fsm_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int IR_W   = DEF_IR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef CON_FSM_STEP_EN
    input  logic       step,
`endif
    con_fsm_if.master  bus
);

    if (IR_W != OP_W + 2 * REG_AW) begin : g_bad_ir_w
        $error("con_fsm: IR_W must equal OP_W + 2*REG_AW");
    end

    // Where a retiring non-HALT instruction goes.
`ifdef CON_FSM_STEP_EN
    localparam state_e ST_NEXT = ST_WAIT;
`else
    localparam state_e ST_NEXT = ST_FETCH;
`endif

    logic [OP_W-1:0] op;
    dec_t            dec;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       retire;
    logic       ir_ld, pc_in, pc_ld, ram_re, ram_wr, reg_we;
    logic       gf_en, in_en, out_en, au_en, mux_s, halted;
    logic [1:0] s;

    assign op = bus.ir[IR_W-1 -: OP_W];

    con_dec #(.OP_W(OP_W)) u_dec (
        .op_i  (op),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        ir_ld     = 1'b0;
        pc_in     = 1'b0;
        pc_ld     = 1'b0;
        ram_re    = 1'b0;
        ram_wr    = 1'b0;
        reg_we    = 1'b0;
        gf_en     = 1'b0;
        in_en     = 1'b0;
        out_en    = 1'b0;
        au_en     = 1'b0;
        mux_s     = 1'b0;
        halted    = 1'b0;
        s         = S_PC;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ram_re = 1'b1;
                s      = S_PC;
                if (bus.mem_ready) begin
                    ir_ld   = 1'b1;
                    pc_in   = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (dec.instr)
                    I_MOVA, I_ADD: begin
                        reg_we = 1'b1;
                        au_en  = 1'b1;
                        mux_s  = 1'b1;
                    end
                    I_SUB: begin
                        reg_we = 1'b1;
                        au_en  = 1'b1;
                        mux_s  = 1'b1;
                        gf_en  = 1'b1;
                    end
                    I_IN: begin
                        reg_we = 1'b1;
                        in_en  = 1'b1;
                        mux_s  = 1'b1;
                    end
                    I_OUT: begin
                        au_en  = 1'b1;
                        out_en = 1'b1;
                    end
                    default: ;
                endcase

                if (dec.illegal) illegal_d = 1'b1;

                if (dec.to_imm) begin
                    state_d = ST_IMM;
                end else if (dec.to_mem) begin
                    state_d = ST_MEM;
                end else begin
                    retire  = 1'b1;
                    state_d = (dec.instr == I_HALT) ? ST_HALT : ST_NEXT;
                end
            end

            ST_IMM: begin
                ram_re = 1'b1;
                s      = S_PC;
                if (bus.mem_ready) begin
                    // PC steps past the immediate exactly once, on the completing cycle;
                    // a concurrent pc_ld overrides it in the datapath (jump taken).
                    pc_in = 1'b1;
                    case (dec.instr)
                        I_MOVI: begin
                            reg_we = 1'b1;
                            mux_s  = 1'b1;
                        end
                        I_JMP:   pc_ld = 1'b1;
                        I_JG:    pc_ld = bus.g;
                        default: ;
                    endcase
                    retire  = 1'b1;
                    state_d = ST_NEXT;
                end
            end

            ST_MEM: begin
                if (dec.instr == I_MOVB) begin
                    ram_wr = 1'b1;
                    s      = S_DR;
                end else begin
                    ram_re = 1'b1;
                    s      = S_SR;
                    reg_we = bus.mem_ready;
                end
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_NEXT;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

`ifdef CON_FSM_STEP_EN
            ST_WAIT: begin
                if (step) state_d = ST_FETCH;
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    assign bus.ir_ld     = ir_ld;
    assign bus.pc_in     = pc_in;
    assign bus.pc_ld     = pc_ld;
    assign bus.ram_re    = ram_re;
    assign bus.ram_wr    = ram_wr;
    assign bus.reg_we    = reg_we;
    assign bus.gf_en     = gf_en;
    assign bus.in_en     = in_en;
    assign bus.out_en    = out_en;
    assign bus.au_en     = au_en;
    assign bus.mux_s     = mux_s;
    assign bus.s         = s;
    assign bus.halted    = halted;
    assign bus.illegal   = illegal_q;
    assign bus.instr_cnt = cnt_q;
    // Register addresses and ALU function come straight from the IR fields.
    assign bus.reg_sr    = bus.ir[REG_AW-1:0];
    assign bus.reg_dr    = bus.ir[2*REG_AW-1:REG_AW];
    assign bus.au_ac     = op;

endmodule

// File: tb/tb_con_fsm.sv
// Bench for con_fsm: directed per-cycle vectors push expected outputs into a scoreboard; a negedge monitor checks them.
module tb_con_fsm;
    import con_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic step_v;

    con_fsm_if ifc ();

    con_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CON_FSM_STEP_EN
        .step  (step_v),
`endif
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {ir_ld,pc_in,pc_ld,ram_re,ram_wr,reg_we,gf_en,in_en,out_en,au_en,mux_s}
    localparam logic [10:0] B_IR_LD  = 11'h400;
    localparam logic [10:0] B_PC_IN  = 11'h200;
    localparam logic [10:0] B_PC_LD  = 11'h100;
    localparam logic [10:0] B_RAM_RE = 11'h080;
    localparam logic [10:0] B_RAM_WR = 11'h040;
    localparam logic [10:0] B_REG_WE = 11'h020;
    localparam logic [10:0] B_GF_EN  = 11'h010;
    localparam logic [10:0] B_IN_EN  = 11'h008;
    localparam logic [10:0] B_OUT_EN = 11'h004;
    localparam logic [10:0] B_AU_EN  = 11'h002;
    localparam logic [10:0] B_MUX_S  = 11'h001;
    localparam logic [10:0] NONE     = 11'h000;
    localparam logic [10:0] FETCH_OK = B_IR_LD | B_PC_IN | B_RAM_RE;

    // Row kinds: normal, WAIT with step low, WAIT with step high (WAIT rows exist only in the step build).
    localparam logic [1:0] NW = 2'd0;
    localparam logic [1:0] WH = 2'd1;
    localparam logic [1:0] WG = 2'd2;

    typedef struct {
        string       name;
        logic [10:0] stb;
        logic [1:0]  s;
        logic [1:0]  dr;
        logic [1:0]  sr;
        logic [3:0]  ac;
        logic        halted;
        logic        illegal;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input string nm, input logic [7:0] ir_v, input logic st, input logic gv,
                       input logic mr, input logic [10:0] stb, input logic [1:0] s_v,
                       input logic h, input logic il, input logic [15:0] cnt, input logic [1:0] w);
        exp_t e;
`ifndef CON_FSM_STEP_EN
        if (w != NW) return;
`else
        step_v = (w == WG);
`endif
        ifc.ir        = ir_v;
        ifc.start     = st;
        ifc.g         = gv;
        ifc.mem_ready = mr;
        e.name    = nm;
        e.stb     = stb;
        e.s       = s_v;
        e.dr      = ir_v[3:2];
        e.sr      = ir_v[1:0];
        e.ac      = ir_v[7:4];
        e.halted  = h;
        e.illegal = il;
        e.cnt     = cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Two WAIT cycles after a retire (step build only): hold, then release with step.
    task automatic gap(input logic [7:0] ir_v, input logic il, input logic [15:0] cnt);
        cyc("wait_hold", ir_v, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, il, cnt, WH);
        cyc("wait_go",   ir_v, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, il, cnt, WG);
    endtask

    // Monitor: pops one expectation per presented cycle and compares every output field.
    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] a_stb;
        logic [38:0] act, req;
        a_stb = {ifc.ir_ld, ifc.pc_in, ifc.pc_ld, ifc.ram_re, ifc.ram_wr, ifc.reg_we,
                 ifc.gf_en, ifc.in_en, ifc.out_en, ifc.au_en, ifc.mux_s};
        if (ifc.ram_re === 1'b1 || ifc.ram_wr === 1'b1) begin
            total++;
            if (ifc.ram_re === 1'b1 && ifc.ram_wr === 1'b1) begin
                bad++;
                $display("FAIL rw_exclusive: got ram_re=1 ram_wr=1, need at most one high");
            end
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            act = {a_stb, ifc.s, ifc.reg_dr, ifc.reg_sr, ifc.au_ac, ifc.halted, ifc.illegal, ifc.instr_cnt};
            req = {e.stb, e.s, e.dr, e.sr, e.ac, e.halted, e.illegal, e.cnt};
            total++;
            if (act !== req) begin
                bad++;
                $display("FAIL %s: got stb=%b s=%b dr=%0d sr=%0d ac=%h halt=%b ill=%b cnt=%0d; need stb=%b s=%b dr=%0d sr=%0d ac=%h halt=%b ill=%b cnt=%0d",
                         e.name, a_stb, ifc.s, ifc.reg_dr, ifc.reg_sr, ifc.au_ac, ifc.halted, ifc.illegal, ifc.instr_cnt,
                         e.stb, e.s, e.dr, e.sr, e.ac, e.halted, e.illegal, e.cnt);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        step_v        = 1'b0;
        ifc.start     = 1'b0;
        ifc.ir        = 8'h16;
        ifc.g         = 1'b0;
        ifc.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then MOVA R1<=R2
        cyc("reset",      8'h16, 1'b0, 1'b0, 1'b0, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        rst_n = 1'b1;
        cyc("idle_start", 8'h16, 1'b1, 1'b0, 1'b0, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("mova_fetch", 8'h16, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("mova_exec",  8'h16, 1'b0, 1'b0, 1'b1, B_REG_WE | B_AU_EN | B_MUX_S, S_PC, 1'b0, 1'b0, 16'd0, NW);
        gap(8'h16, 1'b0, 16'd1);

        // NOP with a 3-cycle fetch stall
        for (int i = 0; i < 3; i++)
            cyc("fetch_stall", 8'h00, 1'b0, 1'b0, 1'b0, B_RAM_RE, S_PC, 1'b0, 1'b0, 16'd1, NW);
        cyc("nop_fetch",  8'h00, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd1, NW);
        cyc("nop_exec",   8'h00, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd1, NW);
        gap(8'h00, 1'b0, 16'd2);

        // JG not taken, then taken
        cyc("jg0_fetch",  8'h80, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd2, NW);
        cyc("jg0_exec",   8'h80, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd2, NW);
        cyc("jg0_imm",    8'h80, 1'b0, 1'b0, 1'b1, B_RAM_RE | B_PC_IN, S_PC, 1'b0, 1'b0, 16'd2, NW);
        gap(8'h80, 1'b0, 16'd3);
        cyc("jg1_fetch",  8'h80, 1'b0, 1'b1, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd3, NW);
        cyc("jg1_exec",   8'h80, 1'b0, 1'b1, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd3, NW);
        cyc("jg1_imm",    8'h80, 1'b0, 1'b1, 1'b1, B_RAM_RE | B_PC_IN | B_PC_LD, S_PC, 1'b0, 1'b0, 16'd3, NW);
        gap(8'h80, 1'b0, 16'd4);

        // MOVI R1 <= imm
        cyc("movi_fetch", 8'h47, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd4, NW);
        cyc("movi_exec",  8'h47, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd4, NW);
        cyc("movi_imm",   8'h47, 1'b0, 1'b0, 1'b1, B_RAM_RE | B_PC_IN | B_REG_WE | B_MUX_S, S_PC, 1'b0, 1'b0, 16'd4, NW);
        gap(8'h47, 1'b0, 16'd5);

        // MOVB M[R0]<=R1 then MOVC R1<=M[R2], each with one RAM stall
        cyc("movb_fetch", 8'h21, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd5, NW);
        cyc("movb_exec",  8'h21, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd5, NW);
        cyc("movb_stall", 8'h21, 1'b0, 1'b0, 1'b0, B_RAM_WR, S_DR, 1'b0, 1'b0, 16'd5, NW);
        cyc("movb_mem",   8'h21, 1'b0, 1'b0, 1'b1, B_RAM_WR, S_DR, 1'b0, 1'b0, 16'd5, NW);
        gap(8'h21, 1'b0, 16'd6);
        cyc("movc_fetch", 8'h36, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd6, NW);
        cyc("movc_exec",  8'h36, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd6, NW);
        cyc("movc_stall", 8'h36, 1'b0, 1'b0, 1'b0, B_RAM_RE, S_SR, 1'b0, 1'b0, 16'd6, NW);
        cyc("movc_mem",   8'h36, 1'b0, 1'b0, 1'b1, B_RAM_RE | B_REG_WE, S_SR, 1'b0, 1'b0, 16'd6, NW);
        gap(8'h36, 1'b0, 16'd7);

        // ALU / IO register instructions
        cyc("add_fetch",  8'h5B, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd7, NW);
        cyc("add_exec",   8'h5B, 1'b0, 1'b0, 1'b1, B_REG_WE | B_AU_EN | B_MUX_S, S_PC, 1'b0, 1'b0, 16'd7, NW);
        gap(8'h5B, 1'b0, 16'd8);
        cyc("sub_fetch",  8'h6B, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd8, NW);
        cyc("sub_exec",   8'h6B, 1'b0, 1'b0, 1'b1, B_REG_WE | B_AU_EN | B_MUX_S | B_GF_EN, S_PC, 1'b0, 1'b0, 16'd8, NW);
        gap(8'h6B, 1'b0, 16'd9);
        cyc("in_fetch",   8'h94, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd9, NW);
        cyc("in_exec",    8'h94, 1'b0, 1'b0, 1'b1, B_REG_WE | B_IN_EN | B_MUX_S, S_PC, 1'b0, 1'b0, 16'd9, NW);
        gap(8'h94, 1'b0, 16'd10);
        cyc("out_fetch",  8'hA1, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd10, NW);
        cyc("out_exec",   8'hA1, 1'b0, 1'b0, 1'b1, B_AU_EN | B_OUT_EN, S_PC, 1'b0, 1'b0, 16'd10, NW);
        gap(8'hA1, 1'b0, 16'd11);
        cyc("jmp_fetch",  8'h70, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd11, NW);
        cyc("jmp_exec",   8'h70, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd11, NW);
        cyc("jmp_imm",    8'h70, 1'b0, 1'b0, 1'b1, B_RAM_RE | B_PC_IN | B_PC_LD, S_PC, 1'b0, 1'b0, 16'd11, NW);
        gap(8'h70, 1'b0, 16'd12);

        // Illegal opcode 0xC, then HALT; start pulses ignored while halted
        cyc("ill_fetch",  8'hC0, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd12, NW);
        cyc("ill_exec",   8'hC0, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd12, NW);
        gap(8'hC0, 1'b1, 16'd13);
        cyc("halt_fetch", 8'hF0, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b1, 16'd13, NW);
        cyc("halt_exec",  8'hF0, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b1, 16'd13, NW);
        for (int i = 0; i < 2; i++)
            cyc("halt_start", 8'hF0, 1'b1, 1'b0, 1'b1, NONE, S_PC, 1'b1, 1'b1, 16'd14, NW);
        cyc("halt_stay",  8'hF0, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b1, 1'b1, 16'd14, NW);
        rst_n = 1'b0;
        cyc("rst_clear",  8'hF0, 1'b0, 1'b0, 1'b0, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        rst_n = 1'b1;

        // Reset asserted mid-cycle during the MOVB write: strobes drop at once, nothing retires
        cyc("idle_start2", 8'h21, 1'b1, 1'b0, 1'b0, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("movb2_fetch", 8'h21, 1'b0, 1'b0, 1'b1, FETCH_OK, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("movb2_exec",  8'h21, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("movb2_stall", 8'h21, 1'b0, 1'b0, 1'b0, B_RAM_WR, S_DR, 1'b0, 1'b0, 16'd0, NW);
        rst_n = 1'b0;
        cyc("rst_mid_wr",  8'h21, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        cyc("rst_hold",    8'h21, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);
        rst_n = 1'b1;
        cyc("idle_after",  8'h21, 1'b0, 1'b0, 1'b1, NONE, S_PC, 1'b0, 1'b0, 16'd0, NW);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, need 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
